// File: rtl/kp_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package kp_pkg;

  typedef enum logic [1:0] {SCAN, DB_PRESS, PRESSED, DB_RELEASE} kp_state_t;

  // Active-low column drive patterns, left column first.
  localparam logic [3:0] COL0 = 4'b0111;
  localparam logic [3:0] COL1 = 4'b1011;
  localparam logic [3:0] COL2 = 4'b1101;
  localparam logic [3:0] COL3 = 4'b1110;

  localparam logic [3:0] ROWS_IDLE = 4'hF;

  function automatic logic onehot_low(input logic [3:0] v);
    return (v == 4'b0111) || (v == 4'b1011) || (v == 4'b1101) || (v == 4'b1110);
  endfunction

  // Rotating the low bit right walks COL0 -> COL1 -> COL2 -> COL3 -> COL0.
  function automatic logic [3:0] next_col(input logic [3:0] c);
    return {c[0], c[3:1]};
  endfunction

endpackage

// File: rtl/kpdecode.sv
// Combinational keypad decode: active-low row/column one-hots to key value.
module kpdecode (
  input  logic [3:0] rows,
  input  logic [3:0] cols,
  output logic [3:0] code
);

  logic [1:0] ri;
  logic [1:0] ci;

  always_comb begin
    ri = 2'd0;
    ci = 2'd0;
    case (rows)
      4'b0111: ri = 2'd0;
      4'b1011: ri = 2'd1;
      4'b1101: ri = 2'd2;
      4'b1110: ri = 2'd3;
      default: ri = 2'd0;
    endcase
    case (cols)
      4'b0111: ci = 2'd0;
      4'b1011: ci = 2'd1;
      4'b1101: ci = 2'd2;
      4'b1110: ci = 2'd3;
      default: ci = 2'd0;
    endcase
  end

  // Layout: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D
  always_comb begin
    code = 4'd0;
    case ({ri, ci})
      4'h0: code = 4'd1;
      4'h1: code = 4'd2;
      4'h2: code = 4'd3;
      4'h3: code = 4'd10;
      4'h4: code = 4'd4;
      4'h5: code = 4'd5;
      4'h6: code = 4'd6;
      4'h7: code = 4'd11;
      4'h8: code = 4'd7;
      4'h9: code = 4'd8;
      4'hA: code = 4'd9;
      4'hB: code = 4'd12;
      4'hC: code = 4'd14;
      4'hD: code = 4'd0;
      4'hE: code = 4'd15;
      default: code = 4'd13;
    endcase
  end

endmodule

// File: rtl/sync2.sv
// Two-flop synchroniser for asynchronous pin inputs.
module sync2 #(
  parameter int W = 4,
  parameter logic [W-1:0] RST_VAL = '1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_reg <= RST_VAL;
      q        <= RST_VAL;
    end else begin
      meta_reg <= d;
      q        <= meta_reg;
    end
  end

endmodule

// File: rtl/kpscan_ctrl.sv
// 4x4 keypad scanner: column scan, press/release debounce, one code per press
// delivered on a valid/ready handshake.
module kpscan_ctrl
  import kp_pkg::*;
#(
  parameter int SETTLE_CYC   = 16,
  parameter int DEBOUNCE_CYC = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] kpr,
  output logic [3:0] kpc,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_held,
  output logic       key_overrun
);

  localparam int MAX_CYC = (SETTLE_CYC > DEBOUNCE_CYC) ? SETTLE_CYC : DEBOUNCE_CYC;
  localparam int CW = $clog2(MAX_CYC);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] DB_LAST     = CW'(DEBOUNCE_CYC - 1);

  kp_state_t     state;
  logic [CW-1:0] cnt;
  logic [3:0]    rs;
  logic [3:0]    rows_lat;
  logic [3:0]    col_lat;
  logic [3:0]    dec_code;

  sync2 #(.W(4), .RST_VAL(ROWS_IDLE)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (kpr),
    .q     (rs)
  );

  kpdecode u_dec (
    .rows (rows_lat),
    .cols (col_lat),
    .code (dec_code)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= SCAN;
      cnt         <= '0;
      kpc         <= COL0;
      rows_lat    <= ROWS_IDLE;
      col_lat     <= COL0;
      key_code    <= 4'd0;
      key_valid   <= 1'b0;
      key_held    <= 1'b0;
      key_overrun <= 1'b0;
    end else begin
      key_overrun <= 1'b0;
      if (key_valid && key_ready) key_valid <= 1'b0;

      case (state)
        SCAN: begin
          if (cnt == SETTLE_LAST) begin
            cnt <= '0;
            if (onehot_low(rs)) begin
              rows_lat <= rs;
              col_lat  <= kpc;
              state    <= DB_PRESS;
            end else begin
              // Idle rows and multi-row (ghost) patterns both just move on.
              kpc <= next_col(kpc);
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DB_PRESS: begin
          if (rs != rows_lat) begin
            state <= SCAN;
            cnt   <= '0;
            kpc   <= next_col(kpc);
          end else if (cnt == DB_LAST) begin
            state       <= PRESSED;
            cnt         <= '0;
            key_code    <= dec_code;
            key_valid   <= 1'b1;
            key_held    <= 1'b1;
            // An accept in this same cycle retires the old code cleanly.
            key_overrun <= key_valid && !key_ready;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        PRESSED: begin
          if (rs == ROWS_IDLE) begin
            state <= DB_RELEASE;
            cnt   <= '0;
          end
        end

        DB_RELEASE: begin
          if (rs != ROWS_IDLE) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == DB_LAST) begin
            state    <= SCAN;
            cnt      <= '0;
            kpc      <= COL0;
            key_held <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state <= SCAN;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
